// File: rtl/vedic_multiplier_8bit.sv
// Unsigned 8x8 Urdhva-Tiryagbhyam multiplier: 2x2 cells compose into 4x4 stages,
// which compose into the 8x8 core, followed by one registered output stage.

module vedic_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic cross_lo;
    logic cross_hi;
    logic vert_hi;
    logic c1;

    assign cross_lo = a_i[1] & b_i[0];
    assign cross_hi = a_i[0] & b_i[1];
    assign vert_hi  = a_i[1] & b_i[1];
    assign c1       = cross_lo & cross_hi;

    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = cross_lo ^ cross_hi;
    assign p_o[2] = c1 ^ vert_hi;
    assign p_o[3] = c1 & vert_hi;
endmodule

module vedic_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    // Quadrant order: 0=LL, 1=HL (a high, b low), 2=LH (a low, b high), 3=HH
    logic [3:0] quad [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_quad
            vedic_2x2 u_cell (
                .a_i (a_i[(gi % 2) * 2 +: 2]),
                .b_i (b_i[(gi / 2) * 2 +: 2]),
                .p_o (quad[gi])
            );
        end
    endgenerate

    logic [5:0] upper;
    assign upper = {4'b0000, quad[0][3:2]}
                 + {2'b00, quad[1]}
                 + {2'b00, quad[2]}
                 + {quad[3], 2'b00};

    assign p_o = {upper, quad[0][1:0]};
endmodule

module vedic_8x8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [7:0] quad [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_quad
            vedic_4x4 u_stage (
                .a_i (a_i[(gi % 2) * 4 +: 4]),
                .b_i (b_i[(gi / 2) * 4 +: 4]),
                .p_o (quad[gi])
            );
        end
    endgenerate

    // (a*b)>>4 never exceeds 12 bits, so this sum cannot overflow.
    logic [11:0] upper;
    assign upper = {8'h00, quad[0][7:4]}
                 + {4'h0, quad[1]}
                 + {4'h0, quad[2]}
                 + {quad[3], 4'h0};

    assign p_o = {upper, quad[0][3:0]};
endmodule

module vedic_multiplier_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result,
    output logic        out_valid
);
    logic [15:0] product;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        valid_q;
    logic        valid_d;

    vedic_8x8 u_core (
        .a_i (a),
        .b_i (b),
        .p_o (product)
    );

    always_comb begin
        result_d = result_q;
        valid_d  = in_valid;
        if (in_valid) begin
            result_d = product;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 16'h0000;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_vedic_multiplier_8bit.sv
// Self-checking bench for vedic_multiplier_8bit: directed corners, streaming,
// asynchronous reset, randomized traffic and an exhaustive sweep against a*b.

module tb_vedic_multiplier_8bit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] result;
    logic        out_valid;

    int checks;
    int errors;

    // Reference state: what the outputs must show after the most recent edge.
    logic [15:0] exp_res;
    logic        exp_valid;

    vedic_multiplier_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, obs, expv, $time);
        end
    endtask

    // One transaction per cycle; operands glitch to random values first so only
    // the values present at the edge may be captured.
    task automatic apply(input logic [7:0] aa, input logic [7:0] bb, input logic v, input bit show);
        @(negedge clk);
        a        = 8'($urandom);
        b        = 8'($urandom);
        in_valid = v;
        #2;
        a = aa;
        b = bb;
        @(posedge clk);
        if (v) exp_res = 16'(aa) * 16'(bb);
        exp_valid = v;
        #1;
        chk("result", result, exp_res);
        chk("out_valid", {15'b0, out_valid}, {15'b0, exp_valid});
        if (show)
            $display("txn a=0x%02h b=0x%02h in_valid=%0b -> result=0x%04h out_valid=%0b",
                     aa, bb, v, result, out_valid);
    endtask

    initial begin
        logic [7:0] da [11];
        logic [7:0] db [11];
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        exp_res   = 16'h0000;
        exp_valid = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("reset_result", result, 16'h0000);
        chk("reset_valid", {15'b0, out_valid}, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: basic, corners, nibble carries, then a back-to-back stream.
        da = '{8'hCD, 8'hFF, 8'h00, 8'h01, 8'hF0, 8'h80, 8'h0F, 8'hA7, 8'h12, 8'hAA, 8'h7F};
        db = '{8'h39, 8'hFF, 8'hA7, 8'hAB, 8'h0F, 8'h02, 8'h0F, 8'h00, 8'h34, 8'h55, 8'h81};
        for (int i = 0; i < 11; i++) apply(da[i], db[i], 1'b1, 1'b1);
        chk("stream_last", result, 16'h3FFF);

        // Idle: valid drops, result holds the last product.
        apply(8'h55, 8'h66, 1'b0, 1'b1);
        apply(8'h01, 8'h02, 1'b0, 1'b1);
        chk("hold_value", result, 16'h3FFF);

        // Asynchronous reset asserted mid-cycle with a nonzero result.
        apply(8'hC3, 8'h5A, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        exp_res   = 16'h0000;
        exp_valid = 1'b0;
        chk("async_rst_result", result, exp_res);
        chk("async_rst_valid", {15'b0, out_valid}, 16'h0000);
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        @(posedge clk);
        #1;
        chk("rst_hold_result", result, 16'h0000);
        chk("rst_hold_valid", {15'b0, out_valid}, 16'h0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        apply(8'h02, 8'h03, 1'b1, 1'b1);

        // Randomized traffic with random valid gaps.
        for (int i = 0; i < 400; i++)
            apply(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);

        // Exhaustive sweep, back-to-back.
        for (int i = 0; i < 65536; i++)
            apply(i[15:8], i[7:0], 1'b1, 1'b0);
        $display("txn exhaustive sweep of 65536 pairs done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
